// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the divider arbiter slice: FSM encoding and divider latency.
package div_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Number of en-high cycles from the first enabled cycle until done is seen, inclusive.
    function automatic int div_lat(input int data_w);
        return data_w + 5;
    endfunction

endpackage

// File: rtl/div_rr_arb.sv
// Combinational round-robin picker: search starts one past the previous winner and wraps.
module div_rr_arb #(
    parameter  int N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    input  logic             en_arb,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    gnt_idx
);

    logic          found;
    logic [IW-1:0] sel;

    // Walk the requesters in priority order last+1, last+2, ... and grant the first active one.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sel     = '0;
        if (en_arb) begin
            for (int i = 1; i <= N_REQ; i++) begin
                sel = IW'((int'(last) + i) % N_REQ);
                if (!found && req[sel]) begin
                    found      = 1'b1;
                    gnt[sel]   = 1'b1;
                    gnt_idx    = sel;
                end
            end
        end
    end

endmodule

// File: rtl/div_subshift.sv
// Fixed-latency shift/subtract divider; dropping en clears it back to the load step.
module div_subshift
    import div_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sign,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              done
);

    localparam int             LAT         = div_lat(DATA_W);
    localparam int             CW          = $clog2(LAT + 1);
    localparam logic [CW-1:0]  C_LAST_STEP = CW'(DATA_W);
    localparam logic [CW-1:0]  C_FIX       = CW'(DATA_W + 1);
    localparam logic [CW-1:0]  C_DONE      = CW'(LAT - 1);

    logic [CW-1:0]   cnt;
    logic [DATA_W-1:0] q_p0;
    logic [DATA_W-1:0] d_p0;
    logic [DATA_W:0]   r_p0;
    logic              neg_q_p0;
    logic              neg_r_p0;
    logic [DATA_W:0]   rem_shift;
    logic [DATA_W:0]   diff;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic is_signed);
        logic signed [DATA_W-1:0] sv;
        sv = $signed(v);
        if (is_signed && (sv < 0)) return $unsigned(-sv);
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] v,
                                                     input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // One restoring-division step on the partial remainder.
    always_comb begin
        rem_shift = {r_p0[DATA_W-1:0], q_p0[DATA_W-1]};
        diff      = rem_shift - {1'b0, d_p0};
    end

    // Step counter: cleared whenever en is low, saturates on the done step.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (cnt != C_DONE) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Datapath: load magnitudes, iterate DATA_W steps, restore signs, then hold until done.
    always_ff @(posedge clk) begin
        if (en) begin
            if (cnt == '0) begin
                // load stage
                q_p0     <= magnitude(dividend, sign);
                d_p0     <= magnitude(divisor, sign);
                r_p0     <= '0;
                neg_q_p0 <= sign & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                neg_r_p0 <= sign & dividend[DATA_W-1];
            end else if (cnt <= C_LAST_STEP) begin
                // iteration stage
                if (!diff[DATA_W]) begin
                    r_p0 <= diff;
                    q_p0 <= {q_p0[DATA_W-2:0], 1'b1};
                end else begin
                    r_p0 <= rem_shift;
                    q_p0 <= {q_p0[DATA_W-2:0], 1'b0};
                end
            end else if (cnt == C_FIX) begin
                // sign restore stage: remainder follows the dividend's sign
                quotient  <= apply_sign(q_p0, neg_q_p0);
                remainder <= apply_sign(r_p0[DATA_W-1:0], neg_r_p0);
            end
        end
    end

    assign done = en && (cnt == C_DONE);

endmodule

// File: rtl/div_arbiter.sv
// Shares one sequential divider among N_REQ requesters with round-robin grants.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int N_REQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_sign,
    input  logic [N_REQ*DATA_W-1:0] req_dividend,
    input  logic [N_REQ*DATA_W-1:0] req_divisor,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_quotient,
    output logic [DATA_W-1:0]       rsp_remainder,
    output logic                    rsp_dbz,
    output logic                    busy
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t            state;
    logic [IW-1:0]     last;
    logic [IW-1:0]     owner;
    logic              sign_l;
    logic [DATA_W-1:0] dvd_l;
    logic [DATA_W-1:0] dvs_l;
    logic [DATA_W-1:0] q_r;
    logic [DATA_W-1:0] r_r;
    logic              dbz_r;

    logic              en_arb;
    logic [N_REQ-1:0]  gnt;
    logic [IW-1:0]     gnt_idx;
    logic              sel_sign;
    logic [DATA_W-1:0] sel_dvd;
    logic [DATA_W-1:0] sel_dvs;

    logic              div_en;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] div_r;
    logic              div_done;

    assign en_arb = (state == ST_IDLE) && !rst;

    div_rr_arb #(.N_REQ(N_REQ)) u_arb (
        .req     (req_valid),
        .last    (last),
        .en_arb  (en_arb),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Route the winner's operands to the latch inputs.
    always_comb begin
        sel_sign = 1'b0;
        sel_dvd  = '0;
        sel_dvs  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                sel_sign = req_sign[i];
                sel_dvd  = req_dividend[i*DATA_W +: DATA_W];
                sel_dvs  = req_divisor[i*DATA_W +: DATA_W];
            end
        end
    end

    assign div_en = (state == ST_RUN);

    div_subshift #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .en        (div_en),
        .sign      (sign_l),
        .dividend  (dvd_l),
        .divisor   (dvs_l),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done)
    );

    // Job sequencer: accept, divide (or short-circuit divide-by-zero), hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            last  <= IW'(N_REQ - 1);
            owner <= '0;
            q_r   <= '0;
            r_r   <= '0;
            dbz_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner  <= gnt_idx;
                        last   <= gnt_idx;
                        sign_l <= sel_sign;
                        dvd_l  <= sel_dvd;
                        dvs_l  <= sel_dvs;
                        if (sel_dvs == '0) begin
                            q_r   <= '1;
                            r_r   <= sel_dvd;
                            dbz_r <= 1'b1;
                            state <= ST_RESP;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (div_done) begin
                        q_r   <= div_q;
                        r_r   <= div_r;
                        dbz_r <= 1'b0;
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready[owner]) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Response valid goes to the owner of the finished job only.
    always_comb begin
        rsp_valid = '0;
        if (state == ST_RESP) rsp_valid[owner] = 1'b1;
    end

    assign req_ready     = gnt;
    assign rsp_quotient  = q_r;
    assign rsp_remainder = r_r;
    assign rsp_dbz       = dbz_r;
    assign busy          = (state != ST_IDLE);

endmodule
